alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  each requester presents an operation.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  operation accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  XLEN  operands.
REQ-007 SHALL have ports req0_ctrl / req1_ctrl  input  4  ALUControl code.
REQ-008 SHALL have ports alu_a, alu_b  output  XLEN  and alu_ctrl  output  4  drive to shared ALU.
REQ-009 SHALL have port alu_result  input  XLEN  combinational result from shared ALU.
REQ-010 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_id  output  1 (requester index), rsp_data  output  XLEN, rsp_err  output  1 (illegal ctrl).

Function
REQ-011 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; no other states.
REQ-012 IDLE: req<g>_ready = 1 only for granted port g, only when req<g>_valid = 1; both readys 0 in EXEC/RESP.
REQ-013 Grant in IDLE: single valid port wins; both valid -> port indicated by round-robin pointer rr.
REQ-014 On handshake (valid & ready at edge) SHALL latch a, b, ctrl, id into internal registers and enter EXEC; rr <= ~id.
REQ-015 EXEC (exactly 1 cycle): alu_a/alu_b/alu_ctrl SHALL equal latched values; at edge, rsp_data <= alu_result, enter RESP.
REQ-016 Outside EXEC, alu_a, alu_b, alu_ctrl SHALL be 0.
REQ-017 Latency: handshake in cycle k -> rsp_valid = 1 in cycle k+2; throughput max one op per 3 cycles.
REQ-018 RESP: rsp_valid = 1, rsp_id/rsp_data/rsp_err stable until rsp_ready = 1 sampled at edge, then IDLE; backpressure unbounded.
REQ-019 Legal ctrl set: 0000,0001,0010,0011,0100,0101,0111,1000,1001,1111; any other -> rsp_err = 1, rsp_data = 0, ALU result ignored.
REQ-020 Requester dropping valid before ready SHALL not be granted; requests are not queued.
REQ-021 New requests arriving in EXEC/RESP SHALL wait (ready = 0); no request is lost if held.

Reset
REQ-022 reset asserted SHALL immediately force state IDLE, rr = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_err = 0, latched regs = 0, alu_* = 0.
REQ-023 reset mid-operation SHALL discard the in-flight op; no response issued for it.
REQ-024 req0_ready/req1_ready SHALL be 0 while reset is asserted.

Configuration
REQ-025 Macro ALU_ARB_FIXED_PRIO_EN defined: port 0 always wins contention, rr unused (held 0).
REQ-026 Macro undefined: round-robin per REQ-013/REQ-014.

Verification
REQ-027 Single op: req0 a=5, b=3, ctrl=0001 -> req0_ready in cycle k, alu_ctrl=0001 in k+1, rsp_valid k+2, rsp_data=2, rsp_id=0, rsp_err=0.
REQ-028 Contention (round-robin build): both valid continuously, rsp_ready=1 -> grant order 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN -> 0,0,0,0.
REQ-029 Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp fields stable, req1_valid=1 sees ready=0 throughout, accepted first IDLE cycle after release.
REQ-030 Illegal ctrl: req1 ctrl=0110 -> rsp_valid with rsp_err=1, rsp_data=0, rsp_id=1.
REQ-031 Reset in EXEC: reset pulse in cycle k+1 -> rsp_valid never asserts for that op, all outputs 0, next req0 handshake succeeds normally.
REQ-032 Idle gating: no requests -> alu_a=alu_b=0, alu_ctrl=0000 every cycle.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter sharing one combinational ALU (IDLE -> EXEC -> RESP).
// Optional macro ALU_ARB_FIXED_PRIO_EN: port 0 always wins contention; otherwise round-robin.
module alu_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    input  logic            req1_valid,
    output logic            req0_ready,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [3:0]      req0_ctrl,
    input  logic [3:0]      req1_ctrl,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_err
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    // one bit per ALUControl code: 0-5, 7, 8, 9 and 15 are legal
    localparam logic [15:0] LEGAL = 16'h83BF;
    state_t state;
    logic rr;
    logic lat_id;
    logic [XLEN-1:0] lat_a;
    logic [XLEN-1:0] lat_b;
    logic [3:0] lat_ctrl;
    logic idle;
    logic grant1;
    // port 1 wins when alone, or on contention when the pointer favours it
    assign idle       = state == IDLE && !reset;
    assign grant1     = req1_valid && (!req0_valid || rr);
    assign req0_ready = idle && req0_valid && !grant1;
    assign req1_ready = idle && grant1;
    assign alu_a      = state == EXEC ? lat_a : '0;
    assign alu_b      = state == EXEC ? lat_b : '0;
    assign alu_ctrl   = state == EXEC ? lat_ctrl : 4'd0;
    assign rsp_valid  = state == RESP;
    // sequencing: latch the granted op, capture the ALU result, hold the response until taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr       <= 1'b0;
            lat_id   <= 1'b0;
            lat_a    <= '0;
            lat_b    <= '0;
            lat_ctrl <= 4'd0;
            rsp_id   <= 1'b0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req0_ready || req1_ready) begin
                    lat_id   <= grant1;
                    lat_a    <= grant1 ? req1_a : req0_a;
                    lat_b    <= grant1 ? req1_b : req0_b;
                    lat_ctrl <= grant1 ? req1_ctrl : req0_ctrl;
`ifdef ALU_ARB_FIXED_PRIO_EN
                    rr       <= 1'b0;
`else
                    rr       <= !grant1;
`endif
                    state    <= EXEC;
                end
                EXEC: begin
                    rsp_id   <= lat_id;
                    rsp_err  <= !LEGAL[lat_ctrl];
                    rsp_data <= LEGAL[lat_ctrl] ? alu_result : '0;
                    state    <= RESP;
                end
                RESP: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed table, corner sequences and random traffic against a transaction-level model.
module tb_alu_arbiter;
    localparam int XLEN = 32;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req0_valid = 1'b0, req1_valid = 1'b0;
    logic req0_ready, req1_ready;
    logic [XLEN-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0] req0_ctrl = 4'd0, req1_ctrl = 4'd0;
    logic [XLEN-1:0] alu_a, alu_b, alu_result;
    logic [3:0] alu_ctrl;
    logic rsp_valid, rsp_id, rsp_err;
    logic rsp_ready = 1'b1;
    logic [XLEN-1:0] rsp_data;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic            id;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      ctrl;
        logic [XLEN-1:0] data;
        logic            err;
    } vec_t;

    typedef struct {
        logic            id;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      ctrl;
    } op_t;

    always #5 clk = ~clk;

    alu_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_ctrl(req0_ctrl), .req1_ctrl(req1_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    // stand-in shared ALU: add, subtract, otherwise a mixing function
    function automatic logic [XLEN-1:0] ext_alu(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [3:0] c);
        return c == 4'd0 ? a + b : c == 4'd1 ? a - b : a ^ b ^ {28'd0, c};
    endfunction

    assign alu_result = ext_alu(alu_a, alu_b, alu_ctrl);

    function automatic bit legal(input logic [3:0] c);
        return c inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd15};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic id, input logic v, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [3:0] c);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_ctrl = c;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_ctrl = c;
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_alu_a"}, alu_a, 0);
        chk({tag, "_alu_b"}, alu_b, 0);
        chk({tag, "_alu_ctrl"}, alu_ctrl, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk_quiet("rst");
        @(negedge clk);
        reset = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
    endtask

    task automatic do_op(input vec_t v);
        @(negedge clk);
        drive(v.id, 1'b1, v.a, v.b, v.ctrl);
        rsp_ready = 1'b1;
        #1;
        chk("op_ready", v.id ? req1_ready : req0_ready, 1);
        chk("op_other_ready", v.id ? req0_ready : req1_ready, 0);
        @(negedge clk);
        drive(v.id, 1'b0, '0, '0, 4'd0);
        #1;
        chk("op_alu_ctrl", alu_ctrl, v.ctrl);
        chk("op_alu_a", alu_a, v.a);
        chk("op_rsp_valid_early", rsp_valid, 0);
        @(negedge clk);
        #1;
        chk("op_rsp_valid", rsp_valid, 1);
        chk("op_rsp_data", rsp_data, v.data);
        chk("op_rsp_id", rsp_id, v.id);
        chk("op_rsp_err", rsp_err, v.err);
        chk("op_alu_idle", alu_ctrl, 0);
    endtask

    vec_t vt[6];
    logic exp_order[4];

    initial begin
        vt[0] = '{1'b0, 32'd5, 32'd3, 4'b0001, 32'd2, 1'b0};
        vt[1] = '{1'b1, 32'd11, 32'd4, 4'b0110, 32'd0, 1'b1};
        vt[2] = '{1'b1, 32'd7, 32'd9, 4'b0000, 32'd16, 1'b0};
        vt[3] = '{1'b0, 32'd1, 32'd2, 4'b1111, 32'd12, 1'b0};
        vt[4] = '{1'b0, 32'd3, 32'd3, 4'b1010, 32'd0, 1'b1};
        vt[5] = '{1'b1, 32'd8, 32'd4, 4'b1001, 32'd5, 1'b0};
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif

        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk_quiet("idle_gate");
        end

        foreach (vt[i]) do_op(vt[i]);

        // contention with both requesters held valid
        do_reset();
        @(negedge clk);
        drive(1'b0, 1'b1, 32'd1, 32'd1, 4'd0);
        drive(1'b1, 1'b1, 32'd2, 32'd2, 4'd0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_ready0", req0_ready, !exp_order[i]);
            chk("cont_ready1", req1_ready, exp_order[i]);
            @(negedge clk);
            @(negedge clk);
            #1;
            chk("cont_rsp_id", rsp_id, exp_order[i]);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, '0, '0, 4'd0);
        drive(1'b1, 1'b0, '0, '0, 4'd0);
        @(negedge clk);
        @(negedge clk);

        // backpressure with a waiting requester
        do_reset();
        @(negedge clk);
        rsp_ready = 1'b0;
        drive(1'b0, 1'b1, 32'd5, 32'd3, 4'b0001);
        #1;
        chk("bp_ready0", req0_ready, 1);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 4'd0);
        drive(1'b1, 1'b1, 32'd7, 32'd9, 4'b0000);
        #1;
        chk("bp_exec_ready1", req1_ready, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, 2);
            chk("bp_rsp_id", rsp_id, 0);
            chk("bp_ready1", req1_ready, 0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready1", req1_ready, 0);
        @(negedge clk);
        #1;
        chk("bp_accept_ready1", req1_ready, 1);
        chk("bp_after_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        drive(1'b1, 1'b0, '0, '0, 4'd0);
        @(negedge clk);
        #1;
        chk("bp_rsp2_data", rsp_data, 16);
        chk("bp_rsp2_id", rsp_id, 1);

        // reset during EXEC discards the op
        do_reset();
        @(negedge clk);
        drive(1'b0, 1'b1, 32'd5, 32'd3, 4'b0001);
        #1;
        chk("rx_ready0", req0_ready, 1);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 4'd0);
        #1;
        chk("rx_alu_ctrl", alu_ctrl, 1);
        reset = 1'b1;
        #1;
        chk_quiet("rx_in_reset");
        chk("rx_rsp_data", rsp_data, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk_quiet("rx_after");
        end
        do_op(vt[0]);

        // random traffic against a transaction-level model
        do_reset();
        begin
            op_t pend[2];
            bit pv[2];
            bit inflight = 0;
            bit pref = 0;
            int hs = 0;
            op_t cur;
            bit er0, er1, erv, eex;
            pv = '{0, 0};
            cur = '{1'b0, '0, '0, 4'd0};
            for (int cyc = 0; cyc < 600; cyc++) begin
                @(negedge clk);
                for (int p = 0; p < 2; p++) begin
                    if (!pv[p] && $urandom_range(0, 2) == 0) begin
                        pv[p] = 1;
                        pend[p] = '{p[0], $urandom, $urandom, 4'($urandom_range(0, 15))};
                    end
                    drive(p[0], pv[p], pv[p] ? pend[p].a : '0, pv[p] ? pend[p].b : '0, pv[p] ? pend[p].ctrl : 4'd0);
                end
                rsp_ready = $urandom_range(0, 3) != 0;
                #1;
                er0 = !inflight && pv[0] && (!pv[1] || !pref);
                er1 = !inflight && pv[1] && (!pv[0] || pref);
                erv = inflight && cyc >= hs + 2;
                eex = inflight && cyc == hs + 1;
                chk("rnd_ready0", req0_ready, er0);
                chk("rnd_ready1", req1_ready, er1);
                chk("rnd_rsp_valid", rsp_valid, erv);
                chk("rnd_alu_a", alu_a, eex ? cur.a : '0);
                chk("rnd_alu_b", alu_b, eex ? cur.b : '0);
                chk("rnd_alu_ctrl", alu_ctrl, eex ? cur.ctrl : 4'd0);
                if (erv) begin
                    chk("rnd_rsp_id", rsp_id, cur.id);
                    chk("rnd_rsp_err", rsp_err, !legal(cur.ctrl));
                    chk("rnd_rsp_data", rsp_data, legal(cur.ctrl) ? ext_alu(cur.a, cur.b, cur.ctrl) : '0);
                    if (rsp_ready) inflight = 0;
                end
                if (er0 || er1) begin
                    cur = er1 ? pend[1] : pend[0];
                    pv[er1] = 0;
                    inflight = 1;
                    hs = cyc;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    pref = !er1;
`endif
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
